// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg
// Shared definitions for the burst RAM model. This package holds the command
// encoding, the controller state enum and the default burst length.
package burst_ram_pkg;

    localparam int DEFAULT_BURST_COUNT = 4;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_READ      = 3'd4
    } state_t;

endpackage

// File: rtl/burst_ram_if.sv
// burst_ram_if
// User-port bundle between a burst master (the cache) and burst_ram.
//   master: drives cmd, cmd_en, addr, wr_data, data_mask;
//           receives rd_data, rd_data_valid, init_calib, busy.
//   slave : the mirror image of master.
// Handshake: a command is taken in any cycle where cmd_en=1, init_calib=1 and
// busy=0. A command offered at any other time is dropped silently, and it
// must not be held in the hope that it is taken later. A write burst streams
// wr_data/data_mask on the accepting cycle and on the next BURST_COUNT-1
// cycles. Read words arrive on rd_data whenever rd_data_valid=1; the master
// cannot stall them.
interface burst_ram_if #(
    parameter int DEPTH_BITWIDTH = 4
);
    logic                      cmd;
    logic                      cmd_en;
    logic [DEPTH_BITWIDTH-1:0] addr;
    logic [63:0]               wr_data;
    logic [7:0]                data_mask;
    logic [63:0]               rd_data;
    logic                      rd_data_valid;
    logic                      init_calib;
    logic                      busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, init_calib, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, init_calib, busy
    );
endinterface

// File: rtl/burst_ram_mem.sv
// burst_ram_mem
// Single-port 64-bit synchronous RAM with per-byte write enables.
//   clk   : clock
//   rst_n : synchronous active-low reset; it clears only the read register
//   re    : read strobe; rdata updates on the next edge
//   we    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; it holds its value when re=0
module burst_ram_mem #(
    parameter int DEPTH_BITWIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      re,
    input  logic [7:0]                we,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [63:0]               wdata,
    output logic [63:0]               rdata
);
    localparam int DEPTH = 1 << DEPTH_BITWIDTH;

    logic [63:0] mem [0:DEPTH-1];

    // The array has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/burst_ram.sv
// burst_ram
// Cycle-level stand-in for the PSRAM controller user port. The controller
// models the calibration delay and takes 4-word read and write bursts with
// byte masking. It returns read data CYCLES_BEFORE_DATA_VALID cycles after
// the read command.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   bus       : user port (burst_ram_if.slave)
//   fsm_state : current controller state, for observation
// Constraints: CYCLES_BEFORE_INITIATED >= 1, CYCLES_BEFORE_DATA_VALID >= 2,
// BURST_COUNT >= 2.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH           = 4,
    parameter int BURST_COUNT              = DEFAULT_BURST_COUNT,
    parameter int CYCLES_BEFORE_INITIATED  = 10,
    parameter int CYCLES_BEFORE_DATA_VALID = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    burst_ram_if.slave      bus,
    output state_t          fsm_state
);
    localparam int CNT_W = 16;

    typedef logic [DEPTH_BITWIDTH-1:0] addr_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    addr_t              burst_addr;
    logic               init_calib_q;
    logic               busy_q;
    logic               valid_q;

    logic               mem_re;
    logic [7:0]         mem_we;
    addr_t              mem_addr;
    logic [63:0]        mem_rdata;

    // The READ_WAIT state ends when the RAM read for word 0 is issued. The
    // synchronous RAM then shows word 0 on the next cycle, which is the
    // cycle L after the command.
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(CYCLES_BEFORE_DATA_VALID - 2);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(CYCLES_BEFORE_INITIATED - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] READ_END   = CNT_W'(BURST_COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            cnt          <= '0;
            burst_addr   <= '0;
            init_calib_q <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == INIT_LAST) begin
                        state        <= ST_IDLE;
                        init_calib_q <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd_en) begin
                        busy_q <= 1'b1;
                        if (bus.cmd == CMD_WRITE) begin
                            // Word 0 is written this cycle, so the burst
                            // continues at addr+1 with word index 1.
                            state      <= ST_WRITE;
                            burst_addr <= bus.addr + addr_t'(1);
                            cnt        <= CNT_W'(1);
                        end else begin
                            state      <= ST_READ_WAIT;
                            burst_addr <= bus.addr;
                            cnt        <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    burst_addr <= burst_addr + addr_t'(1);
                    if (cnt == WRITE_LAST) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READ_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state      <= ST_READ;
                        valid_q    <= 1'b1;
                        burst_addr <= burst_addr + addr_t'(1);
                        cnt        <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    // cnt counts words already issued to the RAM. After the
                    // last word is issued, one more cycle shows it on rd_data.
                    if (cnt == READ_END) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        burst_addr <= burst_addr + addr_t'(1);
                        cnt        <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_re   = 1'b0;
        mem_we   = '0;
        mem_addr = burst_addr;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_en && bus.cmd == CMD_WRITE) begin
                    mem_we   = ~bus.data_mask;
                    mem_addr = bus.addr;
                end
            end
            ST_WRITE: begin
                mem_we = ~bus.data_mask;
            end
            ST_READ_WAIT: begin
                mem_re = (cnt == WAIT_LAST);
            end
            ST_READ: begin
                mem_re = (cnt != READ_END);
            end
            default: begin
                mem_re = 1'b0;
            end
        endcase
        // When reset is asserted during a burst, the word on that edge must
        // not be stored.
        if (!rst_n) begin
            mem_re = 1'b0;
            mem_we = '0;
        end
    end

    burst_ram_mem #(
        .DEPTH_BITWIDTH(DEPTH_BITWIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (mem_re),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus.wr_data),
        .rdata (mem_rdata)
    );

    assign bus.rd_data       = mem_rdata;
    assign bus.rd_data_valid = valid_q;
    assign bus.init_calib    = init_calib_q;
    assign bus.busy          = busy_q;
    assign fsm_state         = state;
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram
// Directed bench for burst_ram. Inputs are driven on the falling edge.
// Outputs are sampled on the falling edge, which is half a cycle after the
// active edge.
module tb_burst_ram;
    import burst_ram_pkg::*;

    localparam int L = 6;

    logic   clk;
    logic   rst_n;
    state_t fsm_state;
    int     tests_run;
    int     tests_failed;

    burst_ram_if #(.DEPTH_BITWIDTH(4)) bus ();

    burst_ram #(
        .DEPTH_BITWIDTH(4),
        .BURST_COUNT(4),
        .CYCLES_BEFORE_INITIATED(10),
        .CYCLES_BEFORE_DATA_VALID(L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pre(int i);
        return {32'hA5A5_A5A5, 32'(i)};
    endfunction

    // ---------------- driver tasks (caller sits on a falling edge) ----------
    // Releases reset and runs through INIT. The task counts cycles where
    // init_calib differs from the expected 0 x9, 1 at k=10, or where
    // rd_data_valid or busy is set. If drop=1, a write command is offered
    // during INIT.
    task automatic release_init(input bit drop, output int err);
        err = 0;
        rst_n = 1'b1;
        bus.cmd_en = drop; bus.cmd = CMD_WRITE; bus.addr = 4'd0;
        bus.wr_data = 64'hDEAD_DEAD_DEAD_DEAD; bus.data_mask = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.init_calib !== (k == 10)) err++;
            if (bus.rd_data_valid !== 1'b0 || bus.busy !== 1'b0) err++;
            bus.cmd_en = drop && (k < 5);
        end
        bus.cmd_en = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [255:0] d,
                            input logic [31:0] m, output int busy_err);
        busy_err = 0;
        bus.cmd_en = 1'b1; bus.cmd = CMD_WRITE; bus.addr = a;
        bus.wr_data = d[63:0]; bus.data_mask = m[7:0];
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.cmd_en = 1'b0;
            if (bus.busy !== (k <= 3)) busy_err++;
            if (k <= 3) begin
                bus.wr_data   = d[64*k +: 64];
                bus.data_mask = m[8*k +: 8];
            end
        end
        bus.wr_data = '0; bus.data_mask = 8'h00;
    endtask

    // Collects the words seen while the valid window is expected to be high.
    // The task counts cycles where valid or busy deviate from the expected
    // timing. If inject=1, a write to address 0 is offered at T+2.
    task automatic do_read(input logic [3:0] a, input bit inject,
                           output logic [255:0] got, output int valid_err,
                           output int busy_err, output logic [63:0] hold);
        got = '0; valid_err = 0; busy_err = 0; hold = '0;
        bus.cmd_en = 1'b1; bus.cmd = CMD_READ; bus.addr = a;
        for (int k = 1; k <= L + 4; k++) begin
            @(negedge clk);
            if (bus.rd_data_valid !== (k >= L && k <= L + 3)) valid_err++;
            if (bus.busy !== (k <= L + 3)) busy_err++;
            if (k >= L && k <= L + 3) got[64*(k-L) +: 64] = bus.rd_data;
            if (k == L + 4) hold = bus.rd_data;
            bus.cmd_en = inject && (k == 2);
            if (inject && k == 2) begin
                bus.cmd = CMD_WRITE; bus.addr = 4'd0;
                bus.wr_data = '0; bus.data_mask = 8'h00;
            end
        end
        bus.cmd_en = 1'b0;
    endtask

    // ---------------- feature tests ----------------
    task automatic test_preload();
        int e;
        logic [255:0] g;
        int ve, be;
        logic [63:0] h;
        for (int b = 0; b < 4; b++) begin
            do_write(4'(4*b), {pre(4*b+3), pre(4*b+2), pre(4*b+1), pre(4*b)}, 32'h0, e);
            tests_run++;
            if (e !== 0) begin
                tests_failed++;
                $display("FAIL preload_busy[%0d]: got %0d bad cycles, want 0", b, e);
            end
        end
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== {pre(3), pre(2), pre(1), pre(0)} || ve !== 0) begin
            tests_failed++;
            $display("FAIL preload_read: got %h (valid_err %0d), want %h", g, ve,
                     {pre(3), pre(2), pre(1), pre(0)});
        end
    endtask

    task automatic test_reset();
        int e;
        logic [255:0] g;
        int ve, be;
        logic [63:0] h;
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.init_calib !== 1'b0 || bus.busy !== 1'b0 || bus.rd_data_valid !== 1'b0 ||
            bus.rd_data !== 64'h0 || fsm_state !== ST_INIT) begin
            tests_failed++;
            $display("FAIL reset_values: got init=%b busy=%b valid=%b rd=%h st=%0d, want 0 0 0 0 %0d",
                     bus.init_calib, bus.busy, bus.rd_data_valid, bus.rd_data, fsm_state, ST_INIT);
        end
        @(negedge clk);
        release_init(1'b1, e);
        tests_run++;
        if (e !== 0) begin
            tests_failed++;
            $display("FAIL reset_init_timing: got %0d bad cycles, want 0", e);
        end
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== {pre(3), pre(2), pre(1), pre(0)}) begin
            tests_failed++;
            $display("FAIL init_cmd_dropped: got %h, want %h", g, {pre(3), pre(2), pre(1), pre(0)});
        end
    endtask

    task automatic test_write_read();
        int e, ve, be;
        logic [255:0] g;
        logic [63:0] h;
        logic [255:0] w;
        w = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_write(4'd4, w, 32'h0, e);
        tests_run++;
        if (e !== 0) begin
            tests_failed++;
            $display("FAIL write_busy_window: got %0d bad cycles, want 0", e);
        end
        do_read(4'd4, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== w) begin
            tests_failed++;
            $display("FAIL write_read_data: got %h, want %h", g, w);
        end
        tests_run++;
        if (ve !== 0) begin
            tests_failed++;
            $display("FAIL read_valid_window: got %0d bad cycles, want 0", ve);
        end
        tests_run++;
        if (be !== 0) begin
            tests_failed++;
            $display("FAIL read_busy_window: got %0d bad cycles, want 0", be);
        end
        tests_run++;
        if (h !== 64'h4444_4444_4444_4444) begin
            tests_failed++;
            $display("FAIL rd_data_hold: got %h, want %h", h, 64'h4444_4444_4444_4444);
        end
    endtask

    task automatic test_byte_mask();
        int e, ve, be;
        logic [255:0] g;
        logic [63:0] h;
        logic [255:0] exp_w;
        exp_w = {pre(3), pre(2), pre(1), 64'hFFFF_FFFF_0000_0000};
        do_write(4'd0, {pre(3), pre(2), pre(1), 64'hFFFF_FFFF_FFFF_FFFF}, 32'hFFFF_FF00, e);
        do_write(4'd0, 256'h0, 32'hFFFF_FFF0, e);
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== exp_w) begin
            tests_failed++;
            $display("FAIL byte_mask_f0: got %h, want %h", g, exp_w);
        end
        do_write(4'd0, {4{64'h0123_4567_89AB_CDEF}}, 32'hFFFF_FFFF, e);
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== exp_w) begin
            tests_failed++;
            $display("FAIL byte_mask_ff: got %h, want %h", g, exp_w);
        end
    endtask

    task automatic test_wrap();
        int e, ve, be;
        logic [255:0] g;
        logic [63:0] h;
        logic [255:0] x;
        x = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
             64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
        do_write(4'd14, x, 32'h0, e);
        do_read(4'd14, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== x) begin
            tests_failed++;
            $display("FAIL wrap_read14: got %h, want %h", g, x);
        end
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== {pre(3), pre(2), 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002}) begin
            tests_failed++;
            $display("FAIL wrap_read0: got %h, want %h", g,
                     {pre(3), pre(2), 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002});
        end
        do_read(4'd12, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== {64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000, pre(13), pre(12)}) begin
            tests_failed++;
            $display("FAIL wrap_read12: got %h, want %h", g,
                     {64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000, pre(13), pre(12)});
        end
    endtask

    task automatic test_busy_drop();
        int ve, be;
        logic [255:0] g;
        logic [63:0] h;
        logic [255:0] exp_w;
        exp_w = {pre(3), pre(2), 64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002};
        do_read(4'd0, 1'b1, g, ve, be, h);
        tests_run++;
        if (g !== exp_w || ve !== 0 || be !== 0) begin
            tests_failed++;
            $display("FAIL busy_drop_burst: got %h ve=%0d be=%0d, want %h ve=0 be=0", g, ve, be, exp_w);
        end
        do_read(4'd0, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== exp_w) begin
            tests_failed++;
            $display("FAIL busy_drop_word0: got %h, want %h", g, exp_w);
        end
    endtask

    task automatic test_reset_mid_write();
        int e, ve, be;
        logic [255:0] g;
        logic [63:0] h;
        bus.cmd_en = 1'b1; bus.cmd = CMD_WRITE; bus.addr = 4'd8;
        bus.wr_data = 64'hAAAA_AAAA_AAAA_AAAA; bus.data_mask = 8'h00;
        @(negedge clk);
        bus.cmd_en = 1'b0;
        bus.wr_data = 64'hBBBB_BBBB_BBBB_BBBB;
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.init_calib !== 1'b0 || bus.rd_data_valid !== 1'b0 ||
            fsm_state !== ST_INIT) begin
            tests_failed++;
            $display("FAIL midwrite_abort: got busy=%b init=%b valid=%b st=%0d, want 0 0 0 %0d",
                     bus.busy, bus.init_calib, bus.rd_data_valid, fsm_state, ST_INIT);
        end
        release_init(1'b0, e);
        tests_run++;
        if (e !== 0) begin
            tests_failed++;
            $display("FAIL midwrite_reinit: got %0d bad cycles, want 0", e);
        end
        do_read(4'd8, 1'b0, g, ve, be, h);
        tests_run++;
        if (g !== {pre(11), pre(10), pre(9), 64'hAAAA_AAAA_AAAA_AAAA}) begin
            tests_failed++;
            $display("FAIL midwrite_contents: got %h, want %h", g,
                     {pre(11), pre(10), pre(9), 64'hAAAA_AAAA_AAAA_AAAA});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        int e;
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus.cmd = 1'b0; bus.cmd_en = 1'b0; bus.addr = '0;
        bus.wr_data = '0; bus.data_mask = 8'h00;
        repeat (3) @(negedge clk);
        release_init(1'b0, e);
        tests_run++;
        if (e !== 0) begin
            tests_failed++;
            $display("FAIL first_init_timing: got %0d bad cycles, want 0", e);
        end
        test_preload();
        test_reset();
        test_write_read();
        test_byte_mask();
        test_wrap();
        test_busy_drop();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
